// File: rtl/requant_pkg.sv
// Shared types and elaboration helpers for the per-channel complex requantiser.
package requant_pkg;

    typedef enum logic [1:0] {
        TRUNC     = 2'd0,
        HALF_AWAY = 2'd1,
        HALF_EVEN = 2'd2
    } round_mode_t;

    localparam int LATENCY = 5;

    function automatic int calc_shift(input int iw, input int ow, input int gf);
        return gf + iw - ow;
    endfunction

    function automatic int calc_prod_width(input int iw, input int gw);
        return iw + gw + 1;
    endfunction

    // Symmetric clamp bound: the most negative code is never produced.
    function automatic int clamp_max(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

endpackage

// File: rtl/requant_chan_if.sv
// Sample stream, runtime control and gain-RAM write port of the requantiser.
interface requant_chan_if #(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 8,
    parameter int GAIN_WIDTH   = 16,
    parameter int CHANNELS     = 2048,
    parameter int CNT_WIDTH    = $clog2(CHANNELS) + 1
);
    // Transfer rule: one sample is taken on every posedge with ce high and
    // emerges LATENCY ce-high edges later; there is no back-pressure path.
    logic                          ce;
    logic [2*INPUT_WIDTH-1:0]      data_in;
    logic                          sync_in;
    logic [1:0]                    round_mode;
    logic                          gain_we;
    logic [$clog2(CHANNELS)-1:0]   gain_waddr;
    logic [GAIN_WIDTH-1:0]         gain_wdata;
    logic [2*OUTPUT_WIDTH-1:0]     data_out;
    logic                          sync_out;
    logic                          ovfl;
    logic [CNT_WIDTH-1:0]          ovfl_count;
    logic [$clog2(CHANNELS)-1:0]   dbg_chan;

    modport master (
        output ce, data_in, sync_in, round_mode, gain_we, gain_waddr, gain_wdata,
        input  data_out, sync_out, ovfl, ovfl_count, dbg_chan
    );

    modport slave (
        input  ce, data_in, sync_in, round_mode, gain_we, gain_waddr, gain_wdata,
        output data_out, sync_out, ovfl, ovfl_count, dbg_chan
    );

endinterface

// File: rtl/requant_round_sat.sv
// One component's rounding (S3) and symmetric saturation (S4) stages.
module requant_round_sat
    import requant_pkg::*;
#(
    parameter int PW    = 35,
    parameter int SHIFT = 18,
    parameter int OW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic signed [PW-1:0] p,
    input  round_mode_t          mode,
    output logic signed [OW-1:0] out,
    output logic                 sat
);
    localparam logic [SHIFT-1:0]     HALF  = SHIFT'(1) << (SHIFT - 1);
    localparam logic signed [PW-1:0] W_MAX = PW'(clamp_max(OW));
    localparam logic signed [PW-1:0] W_MIN = -W_MAX;
    localparam logic signed [OW-1:0] O_MAX = OW'(clamp_max(OW));
    localparam logic signed [OW-1:0] O_MIN = -O_MAX;

    logic signed [PW-1:0] w_q;
    logic [SHIFT-1:0]     w_r;
    logic                 w_inc;
    logic signed [PW-1:0] w_rounded;

    logic signed [PW-1:0] r_rounded;
    logic signed [OW-1:0] r_out;
    logic                 r_sat;

    // The rounded value keeps the full product width so nothing wraps before the clamp.
    always_comb begin
        w_q   = p >>> SHIFT;
        w_r   = p[SHIFT-1:0];
        w_inc = 1'b0;
        case (mode)
            HALF_AWAY: w_inc = p[PW-1] ? (w_r > HALF) : (w_r >= HALF);
            HALF_EVEN: w_inc = (w_r > HALF) || ((w_r == HALF) && w_q[0]);
            default:   w_inc = p[PW-1] && (w_r != '0);
        endcase
        w_rounded = w_q + $signed({{(PW-1){1'b0}}, w_inc});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rounded <= '0;
            r_out     <= '0;
            r_sat     <= 1'b0;
        end else if (ce) begin
            r_rounded <= w_rounded;
            if (r_rounded > W_MAX) begin
                r_out <= O_MAX;
                r_sat <= 1'b1;
            end else if (r_rounded < W_MIN) begin
                r_out <= O_MIN;
                r_sat <= 1'b1;
            end else begin
                r_out <= r_rounded[OW-1:0];
                r_sat <= 1'b0;
            end
        end
    end

    assign out = r_out;
    assign sat = r_sat;

endmodule

// File: rtl/requant_chan.sv
// Per-channel complex requantiser: gain RAM lookup, multiply, round, clamp, frame overflow count.
module requant_chan
    import requant_pkg::*;
#(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 8,
    parameter int GAIN_WIDTH   = 16,
    parameter int GAIN_FRAC    = 8,
    parameter int CHANNELS     = 2048,
    parameter int CNT_WIDTH    = $clog2(CHANNELS) + 1
) (
    input  logic clk,
    input  logic rst,
    requant_chan_if.slave bus
);
    localparam int AW    = $clog2(CHANNELS);
    localparam int SHIFT = calc_shift(INPUT_WIDTH, OUTPUT_WIDTH, GAIN_FRAC);
    localparam int PW    = calc_prod_width(INPUT_WIDTH, GAIN_WIDTH);

    // Unity gain at configuration; reset deliberately leaves the table alone.
    logic [GAIN_WIDTH-1:0] r_gain_ram [CHANNELS] = '{default: GAIN_WIDTH'(1 << GAIN_FRAC)};

    logic [AW-1:0]                  w_chan;
    round_mode_t                    w_mode;
    logic signed [INPUT_WIDTH-1:0]  w_re_in;
    logic signed [INPUT_WIDTH-1:0]  w_im_in;
    logic signed [OUTPUT_WIDTH-1:0] w_re_out;
    logic signed [OUTPUT_WIDTH-1:0] w_im_out;
    logic                           w_re_sat;
    logic                           w_im_sat;
    logic                           w_s4_ovfl;

    logic [AW-1:0]                  r_chan;
    logic signed [INPUT_WIDTH-1:0]  r1_re;
    logic signed [INPUT_WIDTH-1:0]  r1_im;
    logic [GAIN_WIDTH-1:0]          r1_gain;
    round_mode_t                    r1_mode;
    logic                           r1_sync;
    logic signed [PW-1:0]           r2_p_re;
    logic signed [PW-1:0]           r2_p_im;
    round_mode_t                    r2_mode;
    logic                           r2_sync;
    logic                           r3_sync;
    logic                           r4_sync;
    logic [2*OUTPUT_WIDTH-1:0]      r_data_out;
    logic                           r_ovfl;
    logic                           r_sync_out;
    logic [CNT_WIDTH-1:0]           r_acc;
    logic [CNT_WIDTH-1:0]           r_ovfl_count;

    assign w_chan    = bus.sync_in ? '0 : r_chan;
    assign w_re_in   = bus.data_in[2*INPUT_WIDTH-1:INPUT_WIDTH];
    assign w_im_in   = bus.data_in[INPUT_WIDTH-1:0];
    assign w_s4_ovfl = w_re_sat | w_im_sat;

    always_comb begin
        case (bus.round_mode)
            2'd1:    w_mode = HALF_AWAY;
            2'd2:    w_mode = HALF_EVEN;
            default: w_mode = TRUNC;
        endcase
    end

    // Write port ignores ce so software can reload gains while the stream is stalled.
    always_ff @(posedge clk) begin
        if (bus.gain_we) begin
            r_gain_ram[bus.gain_waddr] <= bus.gain_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chan       <= '0;
            r1_re        <= '0;
            r1_im        <= '0;
            r1_gain      <= '0;
            r1_mode      <= TRUNC;
            r1_sync      <= 1'b0;
            r2_p_re      <= '0;
            r2_p_im      <= '0;
            r2_mode      <= TRUNC;
            r2_sync      <= 1'b0;
            r3_sync      <= 1'b0;
            r4_sync      <= 1'b0;
            r_data_out   <= '0;
            r_ovfl       <= 1'b0;
            r_sync_out   <= 1'b0;
            r_acc        <= '0;
            r_ovfl_count <= '0;
        end else if (bus.ce) begin
            r_chan  <= w_chan + AW'(1);
            // Read-first: a same-cycle write to this address is seen next visit.
            r1_re   <= w_re_in;
            r1_im   <= w_im_in;
            r1_gain <= r_gain_ram[w_chan];
            r1_mode <= w_mode;
            r1_sync <= bus.sync_in;

            r2_p_re <= PW'(r1_re) * PW'($signed({1'b0, r1_gain}));
            r2_p_im <= PW'(r1_im) * PW'($signed({1'b0, r1_gain}));
            r2_mode <= r1_mode;
            r2_sync <= r1_sync;

            r3_sync <= r2_sync;
            r4_sync <= r3_sync;

            r_data_out <= {w_re_out, w_im_out};
            r_ovfl     <= w_s4_ovfl;
            r_sync_out <= r4_sync;

            // Count is published together with the sync sample that starts the next frame.
            if (r4_sync) begin
                r_ovfl_count <= r_acc;
                r_acc        <= CNT_WIDTH'(w_s4_ovfl);
            end else if (r_acc != '1) begin
                r_acc <= r_acc + CNT_WIDTH'(w_s4_ovfl);
            end
        end
    end

    requant_round_sat #(.PW(PW), .SHIFT(SHIFT), .OW(OUTPUT_WIDTH)) u_rs_re (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .p    (r2_p_re),
        .mode (r2_mode),
        .out  (w_re_out),
        .sat  (w_re_sat)
    );

    requant_round_sat #(.PW(PW), .SHIFT(SHIFT), .OW(OUTPUT_WIDTH)) u_rs_im (
        .clk  (clk),
        .rst  (rst),
        .ce   (bus.ce),
        .p    (r2_p_im),
        .mode (r2_mode),
        .out  (w_im_out),
        .sat  (w_im_sat)
    );

    assign bus.data_out   = r_data_out;
    assign bus.ovfl       = r_ovfl;
    assign bus.sync_out   = r_sync_out;
    assign bus.ovfl_count = r_ovfl_count;
    assign bus.dbg_chan   = r_chan;

endmodule

// File: tb/tb_requant_chan.sv
// Directed and randomized checks of requant_chan against an arithmetic reference model.
module tb_requant_chan;
    localparam int IW    = 18;
    localparam int OW    = 8;
    localparam int GW    = 16;
    localparam int GF    = 8;
    localparam int CH    = 16;
    localparam int CW    = 5;
    localparam int SHIFT = GF + IW - OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    requant_chan_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .GAIN_WIDTH(GW),
                      .CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

    requant_chan #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .GAIN_WIDTH(GW),
                   .GAIN_FRAC(GF), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Expected entries: {sync, ovfl, re[7:0], im[7:0]}
    logic [17:0] exp_q[$];
    logic [17:0] last_out;
    int          model_gain [CH];
    int          model_chan;
    int          model_acc;
    int          model_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rounding defined by plain integer arithmetic on the exact quotient p / 2^SHIFT.
    function automatic longint ref_round(input longint p, input int mode);
        longint den;
        longint a;
        longint q;
        longint rem;
        den = longint'(1) << SHIFT;
        if (mode == 1) begin
            a = (p < 0) ? -p : p;
            q = (a + den / 2) / den;
            return (p < 0) ? -q : q;
        end else if (mode == 2) begin
            q   = (p >= 0) ? p / den : -((-p + den - 1) / den);
            rem = p - q * den;
            if ((2 * rem > den) || ((2 * rem == den) && ((q & 1) != 0))) q = q + 1;
            return q;
        end
        return p / den;
    endfunction

    function automatic logic [8:0] ref_comp(input int x, input int g, input int mode);
        longint v;
        v = ref_round(longint'(x) * longint'(g), mode);
        if (v > 127)  return {1'b1, 8'h7F};
        if (v < -127) return {1'b1, 8'h81};
        return {1'b0, 8'(v)};
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".data_out"},   32'(bus.data_out),   32'(last_out[15:0]));
        chk({tag, ".ovfl"},       32'(bus.ovfl),       32'(last_out[16]));
        chk({tag, ".sync_out"},   32'(bus.sync_out),   32'(last_out[17]));
        chk({tag, ".ovfl_count"}, 32'(bus.ovfl_count), 32'(model_cnt));
        chk({tag, ".chan"},       32'(bus.dbg_chan),   32'(model_chan));
    endtask

    task automatic step(input bit ce, input int re, input int im, input bit sync,
                        input int mode, input bit we, input int waddr, input int wdata);
        logic [8:0]  cre;
        logic [8:0]  cim;
        logic [17:0] e;
        int          ch;
        bus.ce         = ce;
        bus.data_in    = {IW'(re), IW'(im)};
        bus.sync_in    = sync;
        bus.round_mode = 2'(mode);
        bus.gain_we    = we;
        bus.gain_waddr = 4'(waddr);
        bus.gain_wdata = GW'(wdata);
        @(posedge clk);
        #1;
        if (ce) begin
            ch  = sync ? 0 : model_chan;
            cre = ref_comp(re, model_gain[ch], (mode == 3) ? 0 : mode);
            cim = ref_comp(im, model_gain[ch], (mode == 3) ? 0 : mode);
            exp_q.push_back({sync, cre[8] | cim[8], cre[7:0], cim[7:0]});
            model_chan = (ch + 1) % CH;
            e = exp_q.pop_front();
            if (e[17]) begin
                model_cnt = model_acc;
                model_acc = int'(e[16]);
            end else if (model_acc < (1 << CW) - 1) begin
                model_acc = model_acc + int'(e[16]);
            end
            last_out = e;
        end
        if (we) model_gain[waddr] = wdata;
        check_outputs("step");
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.ce      = 1'b0;
        bus.gain_we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(18'd0);
        model_acc  = 0;
        model_cnt  = 0;
        model_chan = 0;
        last_out   = 18'd0;
        check_outputs("reset");
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) model_gain[i] = 1 << GF;
        bus.ce = 1'b0; bus.data_in = '0; bus.sync_in = 1'b0; bus.round_mode = 2'd0;
        bus.gain_we = 1'b0; bus.gain_waddr = '0; bus.gain_wdata = '0;
        do_reset();

        // Unity gain, exact five ce-cycle latency.
        step(1, 5120, -5120, 1, 0, 0, 0, 0);
        flush(4);
        chk("t1_literal", 32'(bus.data_out), 32'(16'h05FB));

        // Half-way values under each rounding mode, including mode 3.
        step(1, 3584, -2560, 1, 0, 0, 0, 0);
        step(1, 3584, -2560, 1, 1, 0, 0, 0);
        step(1, 3584, -2560, 1, 2, 0, 0, 0);
        step(1, 3584, -2560, 1, 3, 0, 0, 0);
        flush(4);
        for (int n = -6; n <= 6; n++)
            for (int m = 0; m < 4; m++) step(1, n * 512, -n * 512 + 1, 1, m, 0, 0, 0);
        flush(4);

        // Gain 4.0 at full scale saturates both halves; ce stalls mid-pipeline.
        step(0, 0, 0, 0, 0, 1, 0, 1024);
        step(1, 131071, -131072, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 7, 7, 0, 1, 0, 0, 0);
        flush(3);
        chk("t3_literal", 32'(bus.data_out), 32'(16'h7F81));
        chk("t3_ovfl", 32'(bus.ovfl), 32'd1);

        // Per-channel gains, mid-frame rewrite of channel 3 while it is read.
        for (int c = 0; c < CH; c++) step(0, 0, 0, 0, 0, 1, c, 256 * (c + 1));
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < CH; c++)
                step(1, 1024, 1024, c == 0, 0, (f == 0) && (c == 3), 3, 2560);
        flush(4);

        // Saturate channels 2, 7, 9 only.
        step(0, 0, 0, 0, 0, 1, 2, 65535);
        step(0, 0, 0, 0, 0, 1, 7, 65535);
        step(0, 0, 0, 0, 0, 1, 9, 65535);
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < CH; c++) step(1, 1024, -1024, c == 0, 1, 0, 0, 0);
        chk("t5_count", 32'(bus.ovfl_count), 32'd3);

        // Reset mid-frame keeps gains and drops the partial count.
        for (int c = 0; c < 5; c++) step(1, 1024, 1024, c == 0, 0, 0, 0, 0);
        do_reset();
        for (int c = 0; c < CH; c++) step(1, 1024, 1024, c == 0, 0, 0, 0, 0);
        step(1, 1024, 1024, 1, 0, 0, 0, 0);
        flush(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int re;
            int im;
            int g;
            re = int'($urandom_range(0, 262143)) - 131072;
            im = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095)) - 2048
                                             : int'($urandom_range(0, 262143)) - 131072;
            g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 600))
                                             : int'($urandom_range(0, 65535));
            step($urandom_range(0, 9) < 8, re, im, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, CH - 1)), g);
        end
        flush(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
